// File: rtl/turbo_stim_gen.sv
// Frame stimulus generator for TurboInterleaver bring-up.
// Settles, then streams K-symbol frames on the dataIn/look_now/dataInNext handshake.
//
// Ports:
//   clock, notreset      : clock and synchronous active-low reset
//   flag_long_cfg        : frame length select (0=K_SHORT, 1=K_LONG)
//   mode_cfg             : 0 MARKER, 1 RAMP, 2 LFSR, 3 ALL_ONES
//   marker_last          : MARKER at index K-1 (1) or index 0 (0)
//   marker_val           : MARKER symbol value
//   frames_cfg           : frames to send, 0 = continuous
//   data_in_next         : sink accepts the presented symbol
//   byte_stream_in       : presented symbol
//   look_now_in          : framing strobe, low on the last symbol
//   flag_long_in         : latched length flag of the current frame
//   busy                 : high while settling, streaming or in a gap
//   frame_done           : one-cycle pulse after the last symbol is accepted
//   frame_count          : frames completed since reset, wraps at 255
module turbo_stim_gen #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 10,
  parameter int K_SHORT       = 132,
  parameter int K_LONG        = 768,
  parameter int SETTLE_CYCLES = 499,
  parameter int GAP_CYCLES    = 16
) (
  input  logic              clock,
  input  logic              notreset,
  input  logic              flag_long_cfg,
  input  logic [1:0]        mode_cfg,
  input  logic              marker_last,
  input  logic [DATA_W-1:0] marker_val,
  input  logic [3:0]        frames_cfg,
  input  logic              data_in_next,
  output logic [DATA_W-1:0] byte_stream_in,
  output logic              look_now_in,
  output logic              flag_long_in,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_count
);

  typedef enum logic [1:0] {
    S_SETTLE,
    S_STREAM,
    S_GAP,
    S_DONE
  } state_t;

  localparam int CNT_MAX =
    (SETTLE_CYCLES > GAP_CYCLES) ?
    SETTLE_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_END =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_END =
    CNT_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_S =
    ADDR_W'(K_SHORT - 1);
  localparam logic [ADDR_W-1:0] LAST_L =
    ADDR_W'(K_LONG - 1);
  localparam logic [15:0] SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        mode,
    input logic              mlast,
    input logic [DATA_W-1:0] mval,
    input logic [ADDR_W-1:0] idx,
    input logic [ADDR_W-1:0] last,
    input logic [15:0]       s
  );
    logic [DATA_W-1:0] p;
    logic [ADDR_W-1:0] mpos;
    mpos = mlast ? last : '0;
    p = '0;
    unique case (mode)
      2'd0: p = (idx == mpos) ? mval : '0;
      2'd1: p = DATA_W'(idx);
      2'd2: p = s[DATA_W-1:0];
      2'd3: p = '1;
    endcase
    return p;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              long_q, long_d;
  logic [1:0]        mode_q, mode_d;
  logic              mlast_q, mlast_d;
  logic [DATA_W-1:0] mval_q, mval_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              look_q, look_d;
  logic              flong_q, flong_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        count_q, count_d;

  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] last_cfg;
  logic [ADDR_W-1:0] idx_nx;
  logic [15:0]       lfsr_nx;
  logic              accept;
  logic              at_last;
  logic              start;
  logic              counting;
  logic              more;

  assign last_q   = long_q ? LAST_L : LAST_S;
  assign last_cfg = flag_long_cfg ? LAST_L : LAST_S;
  assign idx_nx   = idx_q + 1'b1;
  assign lfsr_nx  = lfsr_step(lfsr_q);
  assign accept   = (state_q == S_STREAM)
                  && data_in_next;
  assign at_last  = (idx_q == last_q);
  assign start    = ((state_q == S_SETTLE)
                  && (cnt_q == SETTLE_END))
                  || ((state_q == S_GAP)
                  && (cnt_q == GAP_END));
  assign counting = ((state_q == S_SETTLE)
                  || (state_q == S_GAP))
                  && !start;
  // Frame limit compares against the count
  // this acceptance is about to produce.
  assign more     = (frames_cfg == 4'd0)
                  || ((count_q + 8'd1)
                  < {4'd0, frames_cfg});

  always_ff @(posedge clock) begin
    if (!notreset) begin
      state_q <= S_SETTLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lfsr_q  <= '0;
      long_q  <= 1'b0;
      mode_q  <= '0;
      mlast_q <= 1'b0;
      mval_q  <= '0;
      byte_q  <= '0;
      look_q  <= 1'b0;
      flong_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      long_q  <= long_d;
      mode_q  <= mode_d;
      mlast_q <= mlast_d;
      mval_q  <= mval_d;
      byte_q  <= byte_d;
      look_q  <= look_d;
      flong_q <= flong_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      start: begin
        state_d = S_STREAM;
        cnt_d   = '0;
      end
      counting: cnt_d = cnt_q + 1'b1;
      accept && at_last: begin
        state_d = more ? S_GAP : S_DONE;
        cnt_d   = '0;
      end
      default: ;
    endcase
  end

  // Symbol registers load on the same edge as
  // idx, so the presented symbol always matches.
  always_comb begin
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    long_d  = long_q;
    mode_d  = mode_q;
    mlast_d = mlast_q;
    mval_d  = mval_q;
    byte_d  = byte_q;
    look_d  = look_q;
    flong_d = flong_q;
    done_d  = 1'b0;
    count_d = count_q;
    unique case (1'b1)
      start: begin
        long_d  = flag_long_cfg;
        mode_d  = mode_cfg;
        mlast_d = marker_last;
        mval_d  = marker_val;
        idx_d   = '0;
        lfsr_d  = SEED;
        byte_d  = pattern(mode_cfg,
                    marker_last, marker_val,
                    '0, last_cfg, SEED);
        look_d  = (last_cfg != '0);
        flong_d = flag_long_cfg;
      end
      accept && at_last: begin
        byte_d  = '0;
        look_d  = 1'b0;
        flong_d = 1'b0;
        done_d  = 1'b1;
        count_d = count_q + 8'd1;
      end
      accept && !at_last: begin
        idx_d   = idx_nx;
        lfsr_d  = lfsr_nx;
        byte_d  = pattern(mode_q, mlast_q,
                    mval_q, idx_nx, last_q,
                    lfsr_nx);
        look_d  = (idx_nx != last_q);
      end
      default: ;
    endcase
    busy_d = (state_d != S_DONE);
  end

  assign byte_stream_in = byte_q;
  assign look_now_in    = look_q;
  assign flag_long_in   = flong_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign frame_count    = count_q;

endmodule
